// File: rtl/isa_pkg.sv
// Shared ISA constants and fetch-state encoding for the instruction-fetch stage.
// Two-word (I-type) instructions are recognised by their top two opcode bits.
package isa_pkg;

  localparam int          PC_W_DEF  = 32;
  localparam logic [1:0]  ITYPE_OPC = 2'b11;
  localparam logic [15:0] NOP_WORD  = 16'h0000;

  typedef enum logic [2:0] {
    VEC_LO,
    VEC_HI,
    FETCH_W0,
    FETCH_W1,
    INT_SLOT
  } if_state_e;

  function automatic logic is_two_word(input logic [15:0] word);
    return word[15:14] == ITYPE_OPC;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid register: catches the memory response that lands while the
// fetch stage is stalled so it can be consumed once the stall releases.
module if_skid_buf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         hold,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear || !hold) begin
      out_valid <= 1'b0;
    end else if (in_valid && !out_valid) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: pipelined 16-bit word fetch, I-type word merging, INT slots.
// Optional macro RESET_VEC_FETCH_EN loads the start PC from M[1]:M[0] after reset.
module if_stage
  import isa_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_rvalid,
  input  logic            stall_in,
  input  logic            flush_in,
  input  logic            jmp_taken_in,
  input  logic [PC_W-1:0] jmp_target_in,
  input  logic            int_req_in,
  output logic [PC_W-1:0] PC_out,
  output logic [15:0]     instruction_out,
  output logic [15:0]     Data_out,
  output logic            INT_out,
  output logic            valid_out
);

  localparam int SKID_W = PC_W + 16;
`ifdef RESET_VEC_FETCH_EN
  localparam if_state_e RESET_STATE = VEC_LO;
`else
  localparam if_state_e RESET_STATE = FETCH_W0;
`endif

  if_state_e       state_q, state_d;
  logic [PC_W-1:0] fetch_pc, pc_d, inflight_pc, word_pc;
  logic            inflight, rsp_valid, word_valid, fetch_req;
  logic [15:0]     opc_q, opc_d, word_data;
  logic            int_pending, int_clr, booting, do_jmp, do_flush;
  logic            skid_valid;
  logic [SKID_W-1:0] skid_data;
  logic            slot_valid_d, slot_int_d;
  logic [PC_W-1:0] slot_pc_d;
  logic [15:0]     slot_ins_d, slot_dat_d;
`ifdef RESET_VEC_FETCH_EN
  logic [15:0]     vec_lo_q, vec_lo_d;
`endif

  // Redirects are ignored while the reset vector is still being read.
  assign booting   = (state_q == VEC_LO) || (state_q == VEC_HI);
  assign do_jmp    = jmp_taken_in & ~booting;
  assign do_flush  = flush_in & ~booting;
  assign rsp_valid = imem_rvalid & inflight;
  assign imem_req  = fetch_req & reset;

  if_skid_buf #(.W(SKID_W)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .clear    (do_jmp | do_flush),
    .hold     (stall_in),
    .in_valid (rsp_valid),
    .in_data  ({inflight_pc, imem_rdata}),
    .out_valid(skid_valid),
    .out_data (skid_data)
  );

  // A word parked in the skid register is always older than a live response.
  assign word_valid           = skid_valid | rsp_valid;
  assign {word_pc, word_data} = skid_valid ? skid_data : {inflight_pc, imem_rdata};

  always_comb begin
    imem_addr = fetch_pc;
    case (state_q)
      VEC_LO:  imem_addr = PC_W'(0);
      VEC_HI:  imem_addr = PC_W'(1);
      default: imem_addr = fetch_pc;
    endcase
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d      = state_q;
    pc_d         = fetch_pc;
    opc_d        = opc_q;
    fetch_req    = 1'b0;
    int_clr      = 1'b0;
    slot_valid_d = valid_out;
    slot_int_d   = INT_out;
    slot_pc_d    = PC_out;
    slot_ins_d   = instruction_out;
    slot_dat_d   = Data_out;
`ifdef RESET_VEC_FETCH_EN
    vec_lo_d     = vec_lo_q;
`endif
    if (do_jmp || do_flush || !stall_in) begin
      slot_valid_d = 1'b0;
      slot_int_d   = 1'b0;
      slot_pc_d    = '0;
      slot_ins_d   = NOP_WORD;
      slot_dat_d   = '0;
    end

    if (do_jmp) begin
      pc_d    = jmp_target_in;
      state_d = FETCH_W0;
    end else if (do_flush) begin
      state_d = FETCH_W0;
    end else if (!stall_in) begin
      case (state_q)
        FETCH_W0: begin
          if (int_pending) begin
            // Rewind to the first unconsumed word; it becomes the return address.
            pc_d    = word_valid ? word_pc : fetch_pc;
            state_d = INT_SLOT;
          end else begin
            fetch_req = 1'b1;
            pc_d      = fetch_pc + PC_W'(1);
            if (word_valid) begin
              if (is_two_word(word_data)) begin
                opc_d   = word_data;
                state_d = FETCH_W1;
              end else begin
                slot_valid_d = 1'b1;
                slot_pc_d    = word_pc;
                slot_ins_d   = word_data;
              end
            end
          end
        end
        FETCH_W1: begin
          fetch_req = 1'b1;
          pc_d      = fetch_pc + PC_W'(1);
          if (word_valid) begin
            slot_valid_d = 1'b1;
            slot_pc_d    = word_pc;
            slot_ins_d   = opc_q;
            slot_dat_d   = word_data;
            state_d      = FETCH_W0;
          end
        end
        INT_SLOT: begin
          fetch_req    = 1'b1;
          pc_d         = fetch_pc + PC_W'(1);
          slot_valid_d = 1'b1;
          slot_int_d   = 1'b1;
          slot_pc_d    = fetch_pc;
          int_clr      = 1'b1;
          state_d      = FETCH_W0;
        end
`ifdef RESET_VEC_FETCH_EN
        VEC_LO: begin
          fetch_req = !inflight && !word_valid;
          if (word_valid) begin
            vec_lo_d = word_data;
            state_d  = VEC_HI;
          end
        end
        VEC_HI: begin
          fetch_req = !inflight && !word_valid;
          if (word_valid) begin
            pc_d    = PC_W'({word_data, vec_lo_q});
            state_d = FETCH_W0;
          end
        end
`endif
        default: state_d = FETCH_W0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= RESET_STATE;
      fetch_pc        <= RESET_PC;
      inflight        <= 1'b0;
      inflight_pc     <= '0;
      opc_q           <= '0;
      int_pending     <= 1'b0;
      valid_out       <= 1'b0;
      INT_out         <= 1'b0;
      PC_out          <= '0;
      instruction_out <= '0;
      Data_out        <= '0;
    end else begin
      state_q         <= state_d;
      fetch_pc        <= pc_d;
      inflight        <= imem_req;
      inflight_pc     <= imem_addr;
      opc_q           <= opc_d;
      int_pending     <= (int_pending & ~int_clr) | int_req_in;
      valid_out       <= slot_valid_d;
      INT_out         <= slot_int_d;
      PC_out          <= slot_pc_d;
      instruction_out <= slot_ins_d;
      Data_out        <= slot_dat_d;
    end
  end

`ifdef RESET_VEC_FETCH_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vec_lo_q <= '0;
    else        vec_lo_q <= vec_lo_d;
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: expected slots are derived by walking the memory image.
// Build with +define+RESET_VEC_FETCH_EN to exercise the reset-vector start.
module tb_if_stage;

`ifdef RESET_VEC_FETCH_EN
  localparam logic [31:0] START = 32'h0000_0100;
`else
  localparam logic [31:0] START = 32'h0000_0000;
`endif

  logic        clk, reset;
  logic [31:0] imem_addr, jmp_target_in, PC_out;
  logic        imem_req, imem_rvalid, stall_in, flush_in, jmp_taken_in, int_req_in;
  logic [15:0] imem_rdata, instruction_out, Data_out;
  logic        INT_out, valid_out;

  logic [15:0] mem [0:1023];

  typedef struct {
    logic        intr;
    logic [31:0] pc;
    logic [15:0] ins;
    logic [15:0] dat;
  } slot_t;

  slot_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    mon_en   = 0;

  if_stage #(.PC_W(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_rdata     (imem_rdata),
    .imem_rvalid    (imem_rvalid),
    .stall_in       (stall_in),
    .flush_in       (flush_in),
    .jmp_taken_in   (jmp_taken_in),
    .jmp_target_in  (jmp_target_in),
    .int_req_in     (int_req_in),
    .PC_out         (PC_out),
    .instruction_out(instruction_out),
    .Data_out       (Data_out),
    .INT_out        (INT_out),
    .valid_out      (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: one-cycle read latency.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= 16'h0;
    end else begin
      imem_rvalid <= imem_req;
      imem_rdata  <= mem[imem_addr[9:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // A slot is handed to decode on every cycle it is valid and not stalled.
  always @(negedge clk) begin : monitor
    slot_t s;
    if (mon_en && reset && valid_out && !stall_in && exp_q.size() > 0) begin
      s = exp_q.pop_front();
      check("slot_int", INT_out, s.intr);
      check("slot_pc", PC_out, s.pc);
      check("slot_ins", instruction_out, s.ins);
      check("slot_dat", Data_out, s.dat);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_walk(input logic [31:0] start, input int n);
    logic [31:0] a;
    logic [15:0] w;
    a = start;
    for (int i = 0; i < n; i++) begin
      w = mem[a[9:0]];
      if (w[15:14] == 2'b11) begin
        exp_q.push_back('{1'b0, a + 32'd1, w, mem[a[9:0] + 10'd1]});
        a = a + 32'd2;
      end else begin
        exp_q.push_back('{1'b0, a, w, 16'h0});
        a = a + 32'd1;
      end
    end
  endtask

  task automatic push_int(input logic [31:0] pc);
    exp_q.push_back('{1'b1, pc, 16'h0, 16'h0});
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_w1(input string tag);
    int n;
    n = 0;
    while (!(imem_rvalid && imem_rdata == 16'h1234) && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_w1_seen"}, imem_rvalid && imem_rdata == 16'h1234, 1);
  endtask

  // Reset is dropped mid-cycle while the stage is busy; everything must clear at once.
  task automatic do_reset();
    mon_en = 0;
    exp_q.delete();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("rst_valid", valid_out, 0);
    check("rst_int", INT_out, 0);
    check("rst_pc", PC_out, 0);
    check("rst_ins", instruction_out, 0);
    check("rst_dat", Data_out, 0);
    check("rst_req", imem_req, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("boot_req", imem_req, 1);
    check("boot_addr", imem_addr, 0);
  endtask

  initial begin
    reset = 1'b0;
    stall_in = 0; flush_in = 0; jmp_taken_in = 0; int_req_in = 0;
    jmp_target_in = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
`ifdef RESET_VEC_FETCH_EN
    mem[0] = 16'h0100;
    mem[1] = 16'h0000;
`endif
    mem[START[9:0] + 10'd4] = 16'hC200;
    mem[START[9:0] + 10'd5] = 16'h1234;

    // Straight line with one merged I-type instruction.
    do_reset();
    push_walk(START, 10);
    mon_en = 1;
`ifndef RESET_VEC_FETCH_EN
    tick();
    check("lat_cycle1_valid", valid_out, 0);
    tick();
    check("lat_cycle2_valid", valid_out, 1);
    check("lat_cycle2_pc", PC_out, START);
    tick();
    check("throughput_pc", PC_out, START + 32'd1);
`endif
    drain("straight");

    // Three-cycle stall mid-stream.
    do_reset();
    push_walk(START, 12);
    mon_en = 1;
    wait (exp_q.size() <= 10 || !reset);
    tick();
    stall_in = 1;
    begin
      logic [31:0] held_pc;
      logic        held_v;
      held_pc = PC_out;
      held_v  = valid_out;
      for (int i = 0; i < 3; i++) begin
        tick();
        check("stall_pc_held", PC_out, held_pc);
        check("stall_valid_held", valid_out, held_v);
        check("stall_no_req", imem_req, 0);
      end
    end
    stall_in = 0;
    drain("stall");

    // Jump (together with a stall) while the immediate word is arriving.
    do_reset();
    push_walk(START, 4);
    mon_en = 1;
    wait_w1("jmp");
    push_walk(32'h40, 4);
    jmp_taken_in = 1; jmp_target_in = 32'h40; stall_in = 1;
    tick();
    jmp_taken_in = 0; stall_in = 0;
    drain("jmp");

    // Interrupt raised during the second word of an I-type instruction.
    do_reset();
    push_walk(START, 5);
    push_int(START + 32'd6);
    push_walk(START + 32'd6, 3);
    mon_en = 1;
    wait_w1("int");
    int_req_in = 1;
    tick();
    int_req_in = 0;
    drain("int");

    // Interrupt and jump in the same cycle: INT slot returns to the target.
    mon_en = 0;
    push_int(32'h80);
    push_walk(32'h80, 3);
    jmp_taken_in = 1; jmp_target_in = 32'h80; int_req_in = 1;
    tick();
    jmp_taken_in = 0; int_req_in = 0;
    mon_en = 1;
    drain("int_jmp");

    // Flush clears the slot; flush with jump behaves as jump.
    do_reset();
    repeat (12) tick();
    check("pre_flush_valid", valid_out, 1);
    flush_in = 1;
    tick();
    flush_in = 0;
    check("flush_clears_valid", valid_out, 0);
    repeat (3) tick();
    push_walk(32'h20, 3);
    flush_in = 1; jmp_taken_in = 1; jmp_target_in = 32'h20;
    tick();
    flush_in = 0; jmp_taken_in = 0;
    check("flush_jmp_valid", valid_out, 0);
    mon_en = 1;
    drain("flush_jmp");

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
